// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the shared memory port for mem_port_arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the memory macro.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_valid;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store, one transaction at a time.
// Ties go to DM by default; defining MEM_ARB_RR_EN switches tie-breaking to round-robin.
module mem_port_arbiter #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int WAIT = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    localparam logic [1:0] LAST_CNT = 2'(WAIT - 1);

    logic [1:0] state;
    logic [1:0] waitCnt;
    logic       owner;
    logic       nextOwner;

`ifdef MEM_ARB_RR_EN
    logic       lastOwner;
`endif

    // A lone requester always wins; only a tie consults the arbitration policy.
    always_comb begin
        nextOwner = OWNER_DM;
        if (bus.if_req && !bus.dm_req) begin
            nextOwner = OWNER_IF;
        end
`ifdef MEM_ARB_RR_EN
        else if (bus.if_req && bus.dm_req && lastOwner == OWNER_DM) begin
            nextOwner = OWNER_IF;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            waitCnt       <= 2'd0;
            owner         <= OWNER_DM;
`ifdef MEM_ARB_RR_EN
            lastOwner     <= OWNER_DM;
`endif
            bus.if_gnt    <= 1'b0;
            bus.dm_gnt    <= 1'b0;
            bus.if_valid  <= 1'b0;
            bus.dm_valid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.if_gnt   <= 1'b0;
            bus.dm_gnt   <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.dm_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.if_req || bus.dm_req) begin
                        state      <= ACCESS;
                        waitCnt    <= 2'd0;
                        owner      <= nextOwner;
`ifdef MEM_ARB_RR_EN
                        lastOwner  <= nextOwner;
`endif
                        bus.mem_en <= 1'b1;
                        if (nextOwner == OWNER_DM) begin
                            bus.dm_gnt    <= 1'b1;
                            bus.mem_addr  <= bus.dm_addr;
                            bus.mem_we    <= bus.dm_we;
                            bus.mem_wdata <= bus.dm_wdata;
                        end else begin
                            bus.if_gnt   <= 1'b1;
                            bus.mem_addr <= bus.if_addr;
                            bus.mem_we   <= 1'b0;
                        end
                    end
                end

                // mem_we still holds the latched store flag on the final edge, so a store skips the rdata capture.
                ACCESS: begin
                    if (waitCnt == LAST_CNT) begin
                        state      <= DONE;
                        waitCnt    <= 2'd0;
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        if (owner == OWNER_IF) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_valid <= 1'b1;
                        end else begin
                            if (!bus.mem_we) begin
                                bus.dm_rdata <= bus.mem_rdata;
                            end
                            bus.dm_valid <= 1'b1;
                        end
                    end else begin
                        waitCnt <= waitCnt + 2'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT=1 (A) and one with WAIT=2 (B), each with its own memory.
// Grant-order expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] memA [256];
    logic [15:0] memB [256];

    mem_port_arbiter_if #(.AW(8), .DW(16)) busA ();
    mem_port_arbiter_if #(.AW(8), .DW(16)) busB ();

    mem_port_arbiter #(.AW(8), .DW(16), .WAIT(1)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    mem_port_arbiter #(.AW(8), .DW(16), .WAIT(2)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    always #5 clk = ~clk;

    assign busA.mem_rdata = memA[busA.mem_addr];
    assign busB.mem_rdata = memB[busB.mem_addr];

    always @(posedge clk) begin
        if (busA.mem_en && busA.mem_we) memA[busA.mem_addr] = busA.mem_wdata;
        if (busB.mem_en && busB.mem_we) memB[busB.mem_addr] = busB.mem_wdata;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit useB, input logic ifReq, input logic [7:0] ifAddr,
                                 input logic dmReq, input logic dmWe, input logic [7:0] dmAddr,
                                 input logic [15:0] dmWdata);
        if (useB) begin
            busB.if_req = ifReq;  busB.if_addr = ifAddr;
            busB.dm_req = dmReq;  busB.dm_we = dmWe;
            busB.dm_addr = dmAddr; busB.dm_wdata = dmWdata;
        end else begin
            busA.if_req = ifReq;  busA.if_addr = ifAddr;
            busA.dm_req = dmReq;  busA.dm_we = dmWe;
            busA.dm_addr = dmAddr; busA.dm_wdata = dmWdata;
        end
    endtask

    task automatic doReset;
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    // Waits up to a bounded number of cycles for dm_valid on B; a timeout counts as a miscompare.
    task automatic waitDmValidB(input string tag);
        bit seen;
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step;
            if (busB.dm_valid) seen = 1;
        end
        checkOutput({tag, " valid seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int          weCount;
        int          validCycle;
        int          nGrants;
        int          grants [8];
        int          expGrant [4];
        int          cnt;
        int          vCount;
        int          vCycle [4];
        logic [15:0] vData [4];
        int          expCycle [3];
        logic [15:0] expWord [3];
        logic [7:0]  nextAddr;
        int          ifGrants;

        for (int i = 0; i < 256; i++) begin
            memA[i] = 16'h0000;
            memB[i] = 16'h0000;
        end
        memA[8'h10] = 16'hA5C3;
        memA[8'h00] = 16'h1111;
        memA[8'h01] = 16'h2222;
        memA[8'h02] = 16'h3333;
        memB[8'h30] = 16'hBEEF;

        doReset;

        // Reset state
        checkOutput("reset A strobes", {26'd0, busA.if_gnt, busA.dm_gnt, busA.if_valid, busA.dm_valid, busA.mem_en, busA.mem_we}, 32'd0);
        checkOutput("reset A mem_addr", 32'(busA.mem_addr), 32'd0);
        checkOutput("reset A mem_wdata", 32'(busA.mem_wdata), 32'd0);
        checkOutput("reset A rdata", {busA.if_rdata, busA.dm_rdata}, 32'd0);
        checkOutput("reset B strobes", {26'd0, busB.if_gnt, busB.dm_gnt, busB.if_valid, busB.dm_valid, busB.mem_en, busB.mem_we}, 32'd0);

        // Single fetch, WAIT=1
        applyStimulus(0, 1, 8'h10, 0, 0, 8'h00, 16'h0000);
        step;
        checkOutput("t1 if_gnt c1", 32'(busA.if_gnt), 32'd1);
        checkOutput("t1 mem_en c1", 32'(busA.mem_en), 32'd1);
        checkOutput("t1 mem_addr c1", 32'(busA.mem_addr), 32'h10);
        checkOutput("t1 mem_we c1", 32'(busA.mem_we), 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        step;
        checkOutput("t1 if_valid c2", 32'(busA.if_valid), 32'd1);
        checkOutput("t1 if_rdata c2", 32'(busA.if_rdata), 32'hA5C3);
        checkOutput("t1 gnt/en c2", {30'd0, busA.if_gnt, busA.mem_en}, 32'd0);
        step;
        checkOutput("t1 if_valid c3", 32'(busA.if_valid), 32'd0);
        checkOutput("t1 if_rdata hold", 32'(busA.if_rdata), 32'hA5C3);

        // Store with WAIT=2, after a load that leaves dm_rdata at BEEF
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h30, 16'h0000);
        step;
        checkOutput("t2 load gnt", 32'(busB.dm_gnt), 32'd1);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        waitDmValidB("t2 load");
        checkOutput("t2 load rdata", 32'(busB.dm_rdata), 32'hBEEF);
        step;

        applyStimulus(1, 0, 8'h00, 1, 1, 8'h20, 16'h1234);
        weCount = 0;
        validCycle = -1;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step; else step;
            if (c == 1) begin
                checkOutput("t2 store gnt c1", 32'(busB.dm_gnt), 32'd1);
                applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
            end
            weCount += int'(busB.mem_we);
            if (busB.dm_valid) validCycle = c;
        end
        checkOutput("t2 mem_we cycles", 32'(weCount), 32'd2);
        checkOutput("t2 dm_valid cycle", 32'(validCycle), 32'd3);
        checkOutput("t2 dm_rdata kept", 32'(busB.dm_rdata), 32'hBEEF);

        applyStimulus(1, 0, 8'h00, 1, 0, 8'h20, 16'h0000);
        step;
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        waitDmValidB("t2 reload");
        checkOutput("t2 reload rdata", 32'(busB.dm_rdata), 32'h1234);

        // Contention, WAIT=1, from a fresh reset
        doReset;
        applyStimulus(0, 1, 8'h00, 1, 0, 8'h01, 16'h0000);
        nGrants = 0;
        for (int c = 1; c <= 20; c++) begin
            step;
            if (busA.if_gnt && nGrants < 8) begin grants[nGrants] = 0; nGrants++; end
            if (busA.dm_gnt && nGrants < 8) begin grants[nGrants] = 1; nGrants++; end
            if (nGrants >= 4) applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        end
`ifdef MEM_ARB_RR_EN
        expGrant = '{0, 1, 0, 1};
`else
        expGrant = '{1, 1, 1, 1};
`endif
        checkOutput("t3 grant count", 32'(nGrants), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3 grant %0d (1=DM)", i), 32'(grants[i]), 32'(expGrant[i]));
        end

        // Reset during the ACCESS of a store on B
        applyStimulus(1, 0, 8'h00, 1, 1, 8'h40, 16'h5555);
        step;
        checkOutput("t4 mem_we before rst", 32'(busB.mem_we), 32'd1);
        #2;
        rst = 1'b1;
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        #1;
        checkOutput("t4 en/we async", {30'd0, busB.mem_en, busB.mem_we}, 32'd0);
        #2;
        rst = 1'b0;
        step;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            cnt += int'(busB.dm_valid) + int'(busB.mem_en);
            step;
        end
        checkOutput("t4 no valid after abort", 32'(cnt), 32'd0);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h20, 16'h0000);
        step;
        checkOutput("t4 post-reset gnt", 32'(busB.dm_gnt), 32'd1);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        waitDmValidB("t4 post-reset");
        checkOutput("t4 post-reset rdata", 32'(busB.dm_rdata), 32'h1234);

        // dm_req pulsed during an IF access must be ignored
        applyStimulus(0, 1, 8'h02, 0, 0, 8'h00, 16'h0000);
        step;
        checkOutput("t5 if_gnt", 32'(busA.if_gnt), 32'd1);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h55, 16'h0000);
        step;
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
        checkOutput("t5 if_valid", 32'(busA.if_valid), 32'd1);
        checkOutput("t5 if_rdata", 32'(busA.if_rdata), 32'h3333);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step;
            cnt += int'(busA.dm_gnt) + int'(busA.mem_en) + int'(busA.dm_valid);
        end
        checkOutput("t5 dm ignored", 32'(cnt), 32'd0);

        // Back-to-back fetches of 0,1,2 with WAIT=1
        applyStimulus(0, 1, 8'h00, 0, 0, 8'h00, 16'h0000);
        nextAddr = 8'h01;
        ifGrants = 0;
        vCount = 0;
        for (int c = 1; c <= 10; c++) begin
            step;
            if (busA.if_gnt) begin
                ifGrants++;
                if (ifGrants < 3) begin
                    applyStimulus(0, 1, nextAddr, 0, 0, 8'h00, 16'h0000);
                    nextAddr = nextAddr + 8'h01;
                end else begin
                    applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000);
                end
            end
            if (busA.if_valid && vCount < 4) begin
                vCycle[vCount] = c;
                vData[vCount] = busA.if_rdata;
                vCount++;
            end
        end
        expCycle = '{2, 5, 8};
        expWord  = '{16'h1111, 16'h2222, 16'h3333};
        checkOutput("t6 valid count", 32'(vCount), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t6 valid cycle %0d", i), 32'(vCycle[i]), 32'(expCycle[i]));
            checkOutput($sformatf("t6 word %0d", i), 32'(vData[i]), 32'(expWord[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing the processor's single-port memory between the instruction-fetch path (feeding the IR load) and the data-memory path (load/store, the path `we_DM` drives). Each requester issues a req/gnt/valid transaction. The block grants one requester, drives the shared memory port for a fixed number of wait cycles, then returns read data with a one-cycle valid pulse. It sits between the controller-sequenced datapath and the memory macro.

## Interface
Parameters:
- `AW`, 8, address width.
- `DW`, 16, data width (processor word).
- `WAIT`, 1, memory access cycles per transaction. Legal range 1–3.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request. Held with `if_addr` until `if_gnt`.
- `if_addr` in AW: fetch address.
- `if_gnt` out 1: fetch grant, one-cycle pulse.
- `if_rdata` out DW: fetched instruction word.
- `if_valid` out 1: `if_rdata` valid, one-cycle pulse.
- `dm_req` in 1: data request. Held with `dm_we`, `dm_addr` and `dm_wdata` until `dm_gnt`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in AW: data address.
- `dm_wdata` in DW: store data.
- `dm_gnt` out 1: data grant, one-cycle pulse.
- `dm_rdata` out DW: load data.
- `dm_valid` out 1: load data valid, or store completion ack; one-cycle pulse.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid by the end of the last `mem_en` cycle.

## Operation
FSM states:
- IDLE:
  - No request: remain in IDLE.
  - Otherwise select an owner, latch owner, address, we and wdata into registers, then go to ACCESS. The request inputs are not re-read after this edge.
- ACCESS:
  - `mem_en`=1. `mem_addr`, `mem_wdata` and `mem_we` come from the latched registers; `mem_we` is forced to 0 for an IF owner.
  - A wait counter runs from 0 to WAIT-1. When the counter reaches WAIT-1, go to DONE.
  - On that same edge, for a read, capture `mem_rdata` into the owner's rdata register.
- DONE:
  - Owner's valid = 1 for exactly one cycle, then return to IDLE.
  - For a store, `dm_rdata` is not updated.
- Grant: the owner's gnt is high exactly during the first ACCESS cycle. The requester may drop its req or change its inputs from the next cycle.
- A req dropped before it is sampled in IDLE is ignored; no grant, no access.
- Owner selection when both requesters are asserted is fixed priority, DM first (see Configuration). A single requester always wins.
- Only one transaction is ever in flight. The non-selected requester stays pending, with no gnt, until a later IDLE.
- Outputs `if_rdata` and `dm_rdata` hold their last captured value between transactions.

## Timing
- Reset (asynchronous, active-high) forces:
  - state IDLE, counter 0;
  - all gnt, valid, `mem_en` and `mem_we` outputs to 0;
  - `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` to 0;
  - last-owner register to DM.
- Reset mid-ACCESS aborts the access: `mem_we` drops immediately, and no valid is issued afterwards.
- Latency, counting the request-sampling edge as edge 0:
  - gnt and first `mem_en` cycle: cycle 1.
  - `mem_en` high: cycles 1..WAIT.
  - valid: cycle WAIT+1.
- Throughput: state is IDLE again from cycle WAIT+2. Back-to-back transactions therefore have a period of WAIT+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MEM_ARB_RR_EN` undefined: fixed priority. On a tie, DM always wins, so a continuously asserted `dm_req` starves fetch.
- `MEM_ARB_RR_EN` defined: round-robin on ties. A last-owner register is updated at each grant, and a tie goes to the requester that was not last served. Reset value is DM, so the first tie after reset goes to IF. A single requester still wins regardless of last owner.

## Test plan
- WAIT=1, reset, `if_req`=1, `if_addr`=8'h10, memory word 16'hA5C3:
  - `if_gnt` in cycle 1;
  - `mem_en`=1 with `mem_addr`=8'h10 in cycle 1;
  - `if_valid`=1 with `if_rdata`=16'hA5C3 in cycle 2.
- Store, WAIT=2, `dm_we`=1, `dm_addr`=8'h20, `dm_wdata`=16'h1234:
  - `mem_we`=1 for exactly 2 cycles;
  - `dm_valid` pulses in cycle 3;
  - `dm_rdata` unchanged;
  - a subsequent load of 8'h20 returns 16'h1234.
- Both requests held high, WAIT=1, 4 transactions:
  - fixed-priority build: grant order DM,DM,DM,DM;
  - `MEM_ARB_RR_EN` build: grant order IF,DM,IF,DM.
- `rst` asserted during the ACCESS of a store:
  - `mem_we` and `mem_en` go to 0 asynchronously;
  - no `dm_valid` is issued;
  - next request after reset completes normally.
- `dm_req` pulsed for one cycle while an IF access is in flight, then dropped: no `dm_gnt` and no memory access for DM.
- Back-to-back IF reads of addresses 0,1,2 with WAIT=1: `if_valid` in cycles 2, 5 and 8, with the correct words.
